// File: rtl/keypad_encoder.sv
// Synchronize, debounce and encode 16 push-buttons into a queued eBCD key stream.
// Optional KEYPAD_AUTOREPEAT_EN re-issues a held key after REP_DELAY, then every REP_PERIOD.
module keypad_encoder #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 5_000_000
) (
  input  logic        clock_50m,
  input  logic        rst,
  input  logic [15:0] pb,
  input  logic        key_ack,
  output logic [4:0]  ebcd,
  output logic        ovf
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
  localparam logic [OW-1:0] FULL    = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;

  logic [15:0]   pb_m, pb_s, pb_last, pb_stable;
  logic [CW-1:0] cnt;
  state_t        state;
  logic [3:0]    key, idx, push_code, head_nxt;
  logic          onehot, is_key, push, rep_hit;
  logic          do_pop, do_push, drop;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [OW-1:0] count, count_nxt, count_left;

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      pb_m      <= '0;
      pb_s      <= '0;
      pb_last   <= '0;
      pb_stable <= '0;
      cnt       <= '0;
    end else begin
      pb_m <= pb;
      pb_s <= pb_m;
      if (pb_s != pb_last) begin
        pb_last <= pb_s;
        cnt     <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (pb_s == pb_last && cnt == CNT_MAX)
        pb_stable <= pb_last;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (pb_stable[i]) idx = 4'(i);
  end

  assign onehot = (pb_stable != '0) &&
                  ((pb_stable & (pb_stable - 16'd1)) == '0);
  assign is_key = pb_stable == (16'd1 << key);

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key   <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (onehot) begin
            key   <= idx;
            state <= HELD;
          end else if (pb_stable != '0) begin
            state <= LOCK;
          end
        HELD:
          if (pb_stable == '0) state <= IDLE;
          else if (!is_key) state <= LOCK;
        LOCK:
          if (pb_stable == '0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt, rep_tgt;
  logic          rep_first;

  assign rep_tgt = rep_first ? RW'(REP_DELAY - 1) : RW'(REP_PERIOD - 1);
  assign rep_hit = (state == HELD) && is_key && (rep_cnt == rep_tgt);

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state != HELD || !is_key) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_hit) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign rep_hit = 1'b0;
  // repeat timing has no hardware in this build
  if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_rep_unused
  end
`endif

  assign push      = (state == IDLE && onehot) || rep_hit;
  assign push_code = (state == IDLE) ? idx : key;

  assign do_pop     = key_ack && (count != '0);
  assign do_push    = push && (count != FULL || do_pop);
  assign drop       = push && count == FULL && !do_pop;
  assign rd_nxt     = rd_ptr + PW'(do_pop);
  assign count_left = count - OW'(do_pop);
  assign count_nxt  = count_left + OW'(do_push);

  // head of queue one edge ahead, so ebcd is a plain register
  always_comb begin
    head_nxt = '0;
    if (count_nxt == '0) head_nxt = '0;
    else if (count_left == '0) head_nxt = push_code;
    else head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clock_50m) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge clock_50m or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ebcd   <= '0;
      ovf    <= 1'b0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PW'(do_push);
      count  <= count_nxt;
      ebcd   <= {count_nxt != '0, head_nxt};
      if (drop) ovf <= 1'b1;
    end
  end

endmodule
